// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: opcodes, ALUOp encodings and the packed
// control bundle carried down the pipeline.
package cpu_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BEQ    = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
  } ctrl_t;

  // All-zero bundle: no register write, no memory access, no branch.
  localparam ctrl_t CTRL_NOP = '{alu_op: 2'b00, alu_src: 1'b0, reg_write: 1'b0,
                                 mem_to_reg: 1'b0, mem_read: 1'b0,
                                 mem_write: 1'b0, branch: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: stalls when the load now in EX writes a register
// that the instruction in ID reads (x0 excluded).
module hazard_detect (
  input  logic       ex_mem_read_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       stall_o
);

  logic w_rd_nonzero;
  logic w_src_match;

  assign w_rd_nonzero = (ex_rd_i != 5'd0);
  // Both sources are compared even when the ID instruction ignores rs2.
  assign w_src_match  = (ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i);
  assign stall_o      = ex_mem_read_i & ex_valid_i & w_rd_nonzero & w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion on flush or load-use stall and
// a saturating bubble counter. Load-use detection is built only when
// ID_EX_HAZARD_DETECT_EN is defined.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              Branch_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [9:0]        funct_i,
  input  logic [4:0]        RS1addr_i,
  input  logic [4:0]        RS2addr_i,
  input  logic [4:0]        RDaddr_i,
  output logic [1:0]        ALUOp_o,
  output logic              ALUSrc_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              Branch_o,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [9:0]        funct_o,
  output logic [4:0]        RS1addr_o,
  output logic [4:0]        RS2addr_o,
  output logic [4:0]        RDaddr_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  ctrl_t             w_ctrl_in;
  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_rs1data;
  logic [DATA_W-1:0] r_rs2data;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc;
  logic [9:0]        r_funct;
  logic [4:0]        r_rs1addr;
  logic [4:0]        r_rs2addr;
  logic [4:0]        r_rdaddr;
  logic              r_valid;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_stall;
  logic              w_bubble;

  assign w_ctrl_in = '{alu_op: ALUOp_i, alu_src: ALUSrc_i, reg_write: RegWrite_i,
                       mem_to_reg: MemtoReg_i, mem_read: MemRead_i,
                       mem_write: MemWrite_i, branch: Branch_i};

`ifdef ID_EX_HAZARD_DETECT_EN
  hazard_detect u_hazard_detect (
    .ex_mem_read_i (r_ctrl.mem_read),
    .ex_valid_i    (r_valid),
    .ex_rd_i       (r_rdaddr),
    .id_rs1_i      (RS1addr_i),
    .id_rs2_i      (RS2addr_i),
    .stall_o       (w_stall)
  );
`else
  assign w_stall = 1'b0;
`endif

  // A simultaneous flush and stall collapse into a single bubble.
  assign w_bubble = w_stall | flush_i;

  // Pipeline register: load the ID bundle, or a zeroed NOP on a bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ctrl    <= CTRL_NOP;
      r_rs1data <= {DATA_W{1'b0}};
      r_rs2data <= {DATA_W{1'b0}};
      r_imm     <= {DATA_W{1'b0}};
      r_pc      <= {DATA_W{1'b0}};
      r_funct   <= 10'd0;
      r_rs1addr <= 5'd0;
      r_rs2addr <= 5'd0;
      r_rdaddr  <= 5'd0;
      r_valid   <= 1'b0;
    end else if (w_bubble) begin
      r_ctrl    <= CTRL_NOP;
      r_rs1data <= {DATA_W{1'b0}};
      r_rs2data <= {DATA_W{1'b0}};
      r_imm     <= {DATA_W{1'b0}};
      r_pc      <= {DATA_W{1'b0}};
      r_funct   <= 10'd0;
      r_rs1addr <= 5'd0;
      r_rs2addr <= 5'd0;
      r_rdaddr  <= 5'd0;
      r_valid   <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_in;
      r_rs1data <= RS1data_i;
      r_rs2data <= RS2data_i;
      r_imm     <= imm_i;
      r_pc      <= pc_i;
      r_funct   <= funct_i;
      r_rs1addr <= RS1addr_i;
      r_rs2addr <= RS2addr_i;
      r_rdaddr  <= RDaddr_i;
      r_valid   <= 1'b1;
    end
  end

  // Bubble counter, saturating at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign ALUOp_o      = r_ctrl.alu_op;
  assign ALUSrc_o     = r_ctrl.alu_src;
  assign RegWrite_o   = r_ctrl.reg_write;
  assign MemtoReg_o   = r_ctrl.mem_to_reg;
  assign MemRead_o    = r_ctrl.mem_read;
  assign MemWrite_o   = r_ctrl.mem_write;
  assign Branch_o     = r_ctrl.branch;
  assign RS1data_o    = r_rs1data;
  assign RS2data_o    = r_rs2data;
  assign imm_o        = r_imm;
  assign pc_o         = r_pc;
  assign funct_o      = r_funct;
  assign RS1addr_o    = r_rs1addr;
  assign RS2addr_o    = r_rs2addr;
  assign RDaddr_o     = r_rdaddr;
  assign valid_o      = r_valid;
  assign stall_o      = w_stall;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage (CNT_W=4); stall expectations follow
// whether ID_EX_HAZARD_DETECT_EN is defined.
`timescale 1ns/1ps
module tb_id_ex_stage;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [1:0]  ALUOp_i = 2'd0;
  logic        ALUSrc_i = 1'b0, RegWrite_i = 1'b0, MemtoReg_i = 1'b0;
  logic        MemRead_i = 1'b0, MemWrite_i = 1'b0, Branch_i = 1'b0;
  logic [31:0] RS1data_i = 32'd0, RS2data_i = 32'd0, imm_i = 32'd0, pc_i = 32'd0;
  logic [9:0]  funct_i = 10'd0;
  logic [4:0]  RS1addr_i = 5'd0, RS2addr_i = 5'd0, RDaddr_i = 5'd0;
  logic [1:0]  ALUOp_o;
  logic        ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o;
  logic [31:0] RS1data_o, RS2data_o, imm_o, pc_o;
  logic [9:0]  funct_o;
  logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
  logic        valid_o, stall_o;
  logic [3:0]  bubble_cnt_o;

  id_ex_stage #(.DATA_W(32), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
    .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Branch_i(Branch_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
    .imm_i(imm_i), .pc_i(pc_i), .funct_i(funct_i), .RS1addr_i(RS1addr_i),
    .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
    .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .Branch_o(Branch_o), .RS1data_o(RS1data_o), .RS2data_o(RS2data_o),
    .imm_o(imm_o), .pc_o(pc_o), .funct_o(funct_o), .RS1addr_o(RS1addr_o),
    .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o), .valid_o(valid_o),
    .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string        nm;
    bit           stall;
    logic [199:0] outs;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] m_cnt    = 4'd0;

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [199:0] dut_outs();
    return 200'({valid_o, bubble_cnt_o, ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o,
                 MemRead_o, MemWrite_o, Branch_o, RS1data_o, RS2data_o, imm_o, pc_o,
                 funct_o, RS1addr_o, RS2addr_o, RDaddr_o});
  endfunction

  // ctrl = {ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, Branch}
  task automatic set_id(input logic [7:0] ctrl, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] im, input logic [31:0] pc, input logic [9:0] fn,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd);
    {ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i} = ctrl;
    RS1data_i = d1; RS2data_i = d2; imm_i = im; pc_i = pc; funct_i = fn;
    RS1addr_i = a1; RS2addr_i = a2; RDaddr_i = rd;
  endtask

  // haz_stall: hand-derived load-use stall for this vector when detection is built.
  task automatic cyc(input bit flush, input bit haz_stall, input string nm);
    exp_t e;
    bit   bub;
    flush_i = flush;
    e.nm    = nm;
    e.stall = HAZ & haz_stall;
    bub     = e.stall | flush;
    if (bub) begin
      m_cnt  = (m_cnt == 4'd15) ? 4'd15 : m_cnt + 4'd1;
      e.outs = 200'({1'b0, m_cnt, 161'd0});
    end else begin
      e.outs = 200'({1'b1, m_cnt, ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i,
                     MemWrite_i, Branch_i, RS1data_i, RS2data_i, imm_i, pc_i, funct_i,
                     RS1addr_i, RS2addr_i, RDaddr_i});
    end
    sb_q.push_back(e);
    @(negedge clk_i); #1;
  endtask

  // Monitor: sample stall before the edge, compare the registered bundle after it.
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(negedge clk_i); #3;
      s = stall_o;
      @(posedge clk_i); #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({"stall_", e.nm}, 200'(s), 200'(e.stall));
        chk({"out_", e.nm}, dut_outs(), e.outs);
      end
    end
  end

  initial begin
    #2;
    chk("reset_outs", dut_outs(), 200'd0);
    chk("reset_stall", 200'(stall_o), 200'd0);
    @(negedge clk_i); #1;
    rst_i = 1'b0;

    set_id(8'b10_0_1_0_0_0_0, 32'd5, 32'd7, 32'd0, 32'h100, 10'h000, 5'd1, 5'd2, 5'd3);
    cyc(1'b0, 1'b0, "rtype");
    set_id(8'b00_1_1_1_1_0_0, 32'd11, 32'd0, 32'd8, 32'h104, 10'h002, 5'd1, 5'd0, 5'd5);
    cyc(1'b0, 1'b0, "lw_rd5");
    set_id(8'b10_0_1_0_0_0_0, 32'd20, 32'd30, 32'd0, 32'h108, 10'h000, 5'd4, 5'd5, 5'd6);
    cyc(1'b0, 1'b1, "loaduse_rs2");
    cyc(1'b0, 1'b0, "dependent");
    set_id(8'b00_1_1_1_1_0_0, 32'd40, 32'd0, 32'd4, 32'h10c, 10'h002, 5'd2, 5'd0, 5'd0);
    cyc(1'b0, 1'b0, "lw_rd0");
    set_id(8'b10_0_1_0_0_0_0, 32'd1, 32'd2, 32'd0, 32'h110, 10'h100, 5'd0, 5'd3, 5'd7);
    cyc(1'b0, 1'b0, "x0_immune");
    set_id(8'b01_0_0_0_0_0_1, 32'd9, 32'd9, 32'h10, 32'h114, 10'h000, 5'd8, 5'd9, 5'd0);
    cyc(1'b1, 1'b0, "flush_only");
    set_id(8'b00_1_1_1_1_0_0, 32'd50, 32'd0, 32'd12, 32'h118, 10'h002, 5'd3, 5'd0, 5'd9);
    cyc(1'b0, 1'b0, "lw_rd9");
    set_id(8'b00_1_0_0_0_1_0, 32'd60, 32'd70, 32'd0, 32'h11c, 10'h002, 5'd9, 5'd1, 5'd0);
    cyc(1'b1, 1'b1, "flush_and_stall");
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, "flush_sat");

    set_id(8'b00_1_1_1_1_0_0, 32'd80, 32'd0, 32'd0, 32'h120, 10'h002, 5'd1, 5'd0, 5'd12);
    cyc(1'b0, 1'b0, "lw_rd12");
    set_id(8'b10_0_1_0_0_0_0, 32'd1, 32'd2, 32'd0, 32'h124, 10'h000, 5'd3, 5'd12, 5'd13);
    flush_i = 1'b0;
    #1;
    chk("midstall_stall", 200'(stall_o), 200'(HAZ));
    rst_i = 1'b1;
    #1;
    chk("async_rst_outs", dut_outs(), 200'd0);
    chk("async_rst_stall", 200'(stall_o), 200'd0);
    m_cnt = 4'd0;
    @(negedge clk_i); #1;
    rst_i = 1'b0;
    cyc(1'b0, 1'b0, "after_reset");

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
      @(negedge clk_i); #1;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage RV32I core. It captures the decoded control bundle from the Control unit, plus register-file operands, immediate, funct bits, register addresses and PC. It presents them to the EX stage one cycle later. It also detects load-use hazards, inserts bubbles on hazard or branch flush, and counts inserted bubbles.

## Interface
Parameters:
- DATA_W, 32, operand/immediate/PC width
- CNT_W, 16, bubble counter width

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  branch taken in ID; current ID instruction must not enter EX
- ALUOp_i  in  2  from Control
- ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i  in  1 each  from Control
- RS1data_i, RS2data_i  in  DATA_W  register-file read data
- imm_i  in  DATA_W  sign-extended immediate
- pc_i  in  DATA_W  PC of ID instruction
- funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  5  ID register addresses
- ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o  out  2/1  registered control
- RS1data_o, RS2data_o, imm_o, pc_o  out  DATA_W  registered data
- funct_o  out  10; RS1addr_o, RS2addr_o, RDaddr_o  out  5  registered fields
- valid_o  out  1  EX slot holds a real instruction
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt_o  out  CNT_W  saturating count of bubbles inserted

## Operation
- Normal cycle (no stall, no flush): all _o registers load their _i values on the edge; valid_o <= 1.
- Load-use hazard: stall_o = MemRead_o & valid_o & (RDaddr_o != 0) & (RDaddr_o == RS1addr_i | RDaddr_o == RS2addr_i).
  - Both source addresses are always compared, regardless of instruction type.
- Bubble condition: stall_o | flush_i.
  - On a bubble, every _o register loads 0, including the data fields, and valid_o <= 0.
  - A zeroed bundle is a NOP: no register write, no memory access, no branch.
- flush_i and stall_o together: a single bubble is inserted, counted once.
- stall_o never asserts two consecutive cycles for the same load: after the bubble, MemRead_o is 0.
- Counter: bubble_cnt_o increments by 1 on each bubble edge. It saturates at 2^CNT_W-1 and never wraps.
- Reset: all outputs 0, valid_o 0, bubble_cnt_o 0. Reset asserted mid-stall clears the EX slot immediately. stall_o falls to 0 because it depends on the cleared MemRead_o and valid_o.

## Timing
- Latency: 1 cycle from ID inputs to EX outputs.
- stall_o is combinational from current EX registers and current ID addresses. It must be stable before the edge for the PC and IF/ID hold.
- Load-use penalty: exactly 1 bubble cycle. The dependent instruction enters EX on the second edge after the load entered EX.
- Flush penalty: 1 bubble cycle per flush_i cycle.

## Configuration
- ID_EX_HAZARD_DETECT_EN defined: load-use detection as above.
- ID_EX_HAZARD_DETECT_EN undefined:
  - stall_o is tied to 0; bubbles come only from flush_i.
  - Software must schedule a gap after every load.
  - bubble_cnt_o counts flushes only.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants (R_TYPE, I_TYPE, LW, SW, BEQ)
  - ALUOp encodings
  - a packed ctrl_t typedef bundling ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, Branch
  - the zero constant CTRL_NOP
- One sub-module: hazard_detect. It is purely combinational, takes EX MemRead/valid/RDaddr and ID RS1/RS2 addresses, and produces stall_o. It is instantiated only under ID_EX_HAZARD_DETECT_EN.

## Test plan
- Reset then normal flow:
  - Stimulus: rst_i pulse; present R-type with RegWrite_i=1, RS1data_i=5, RS2data_i=7, RDaddr_i=3.
  - Required: all outputs 0 during reset; after one edge, RegWrite_o=1, RS1data_o=5, RS2data_o=7, RDaddr_o=3, valid_o=1.
- Load-use:
  - Stimulus: LW with RDaddr_i=5 enters EX; next ID has RS2addr_i=5.
  - Required: stall_o=1 that cycle; next edge valid_o=0, all control 0, bubble_cnt_o=1; dependent instruction appears one cycle later with stall_o=0.
- x0 immunity:
  - Stimulus: LW with RDaddr_i=0 in EX; ID RS1addr_i=0.
  - Required: stall_o=0; no bubble.
- Flush + stall together:
  - Stimulus: flush_i=1 in the same cycle as a load-use hazard.
  - Required: one bubble; bubble_cnt_o increments by exactly 1.
- Saturation:
  - Stimulus: CNT_W=4; 20 consecutive flush_i cycles.
  - Required: bubble_cnt_o stops at 15.
- Async reset mid-stall:
  - Stimulus: assert rst_i between edges while stall_o=1.
  - Required: outputs clear without waiting for a clock edge; stall_o drops to 0.
